// File: rtl/resp_demux2_if.sv
// Signal bundle between the shared request/response bus and the response demux.
// Handshake: an issue is accepted on a rising clk edge iff issue_valid && issue_ready;
// issue_ready depends only on registered state. Responses carry no backpressure:
// resp_valid is consumed in the cycle it is presented.
interface resp_demux2_if #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 3
);
  logic             issue_valid;
  logic             issue_sel;
  logic             issue_ready;
  logic             resp_valid;
  logic [WIDTH-1:0] resp_data;
  logic             out_a_valid;
  logic [WIDTH-1:0] out_a_data;
  logic             out_b_valid;
  logic [WIDTH-1:0] out_b_data;
  logic [CNTW-1:0]  pending;
  logic             err_underflow;

  // Bus side: drives issues and responses, observes the routed outputs.
  modport master (
    output issue_valid, issue_sel, resp_valid, resp_data,
    input  issue_ready, out_a_valid, out_a_data, out_b_valid, out_b_data,
           pending, err_underflow
  );

  // Demux side.
  modport slave (
    input  issue_valid, issue_sel, resp_valid, resp_data,
    output issue_ready, out_a_valid, out_a_data, out_b_valid, out_b_data,
           pending, err_underflow
  );
endinterface

// File: rtl/resp_demux2.sv
// Response router for a 2:1 shared data port. An in-order tag FIFO remembers
// which requester (A=0, B=1) issued each accepted request; every response pops
// the oldest tag and is forwarded one cycle later to that requester.
module resp_demux2 #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNTW  = 3
) (
  input logic          clk,
  input logic          reset,
  resp_demux2_if.slave bus
);
  localparam int PW = $clog2(DEPTH);

  logic             tags_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0]  pending_q, pending_d;
  logic             out_a_valid_q, out_b_valid_q;
  logic [WIDTH-1:0] out_a_data_q, out_b_data_q;
  logic             err_q;

  logic push, pop, pop_tag, ready;

  // Full is judged from the registered count only, so a same-cycle pop never
  // opens a slot for a same-cycle push.
  assign ready   = (pending_q != CNTW'(DEPTH));
  assign push    = bus.issue_valid && ready;
  // No bypass: a response is matched only against tags already stored.
  assign pop     = bus.resp_valid && (pending_q != '0);
  assign pop_tag = tags_q[rd_ptr_q];

  // Outstanding count: push and pop in the same cycle cancel out.
  always_comb begin
    pending_d = pending_q;
    if (push && !pop)      pending_d = pending_q + CNTW'(1);
    else if (pop && !push) pending_d = pending_q - CNTW'(1);
  end

  // Tag FIFO storage and pointers; pointers wrap modulo DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) tags_q[i] <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      pending_q <= '0;
    end else begin
      if (push) begin
        tags_q[wr_ptr_q] <= bus.issue_sel;
        wr_ptr_q         <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      pending_q <= pending_d;
    end
  end

  // Routed outputs: one-cycle valid pulse to the tagged port; data of the
  // port not receiving a response holds its last value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_a_valid_q <= 1'b0;
      out_b_valid_q <= 1'b0;
      out_a_data_q  <= '0;
      out_b_data_q  <= '0;
    end else begin
      out_a_valid_q <= pop && !pop_tag;
      out_b_valid_q <= pop && pop_tag;
      if (pop && !pop_tag) out_a_data_q <= bus.resp_data;
      if (pop && pop_tag)  out_b_data_q <= bus.resp_data;
    end
  end

  // Sticky underflow flag: a response arrived with nothing outstanding.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else if (bus.resp_valid && (pending_q == '0)) err_q <= 1'b1;
  end

  assign bus.issue_ready   = ready;
  assign bus.out_a_valid   = out_a_valid_q;
  assign bus.out_a_data    = out_a_data_q;
  assign bus.out_b_valid   = out_b_valid_q;
  assign bus.out_b_data    = out_b_data_q;
  assign bus.pending       = pending_q;
  assign bus.err_underflow = err_q;
endmodule

// File: tb/tb_resp_demux2.sv
// Bench for resp_demux2: directed scenarios plus random traffic, checked
// against a queue-based reference model of the tag ordering.
module tb_resp_demux2;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CNTW  = 3;

  logic clk;
  logic reset;

  resp_demux2_if #(.WIDTH(WIDTH), .CNTW(CNTW)) bus ();

  resp_demux2 #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / model state ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic             m_tags [$];          // outstanding requester tags, oldest first
  logic [WIDTH:0]   exp_q  [$];          // expected routed responses {sel, data}
  logic             m_av, m_bv, m_err;
  logic [WIDTH-1:0] m_ad, m_bd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_tags.delete();
    exp_q.delete();
    m_av = 1'b0; m_bv = 1'b0; m_err = 1'b0;
    m_ad = '0;   m_bd = '0;
  endtask

  task automatic check_outputs();
    logic [WIDTH:0] e;
    check("pending",       32'(bus.pending),     32'(m_tags.size()));
    check("out_a_valid",   32'(bus.out_a_valid), 32'(m_av));
    check("out_b_valid",   32'(bus.out_b_valid), 32'(m_bv));
    check("out_a_data",    bus.out_a_data,       m_ad);
    check("out_b_data",    bus.out_b_data,       m_bd);
    check("err_underflow", 32'(bus.err_underflow), 32'(m_err));
    if (bus.out_a_valid || bus.out_b_valid) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_pulse", 32'(1), 32'(0));
      end else begin
        e = exp_q.pop_front();
        check("sb_route_sel", 32'(bus.out_b_valid), 32'(e[WIDTH]));
        check("sb_route_data", bus.out_b_valid ? bus.out_b_data : bus.out_a_data, e[WIDTH-1:0]);
      end
    end
  endtask

  // Drive one cycle of inputs (starting just after a rising edge), advance
  // the model by one transaction step, then check after the next edge.
  task automatic step(input logic iv, input logic isel, input logic rv, input logic [WIDTH-1:0] rd);
    logic full, sel;
    bus.issue_valid = iv;
    bus.issue_sel   = isel;
    bus.resp_valid  = rv;
    bus.resp_data   = rd;
    #1;
    full = (m_tags.size() == DEPTH);
    check("issue_ready", 32'(bus.issue_ready), 32'(!full));
    m_av = 1'b0;
    m_bv = 1'b0;
    if (rv && m_tags.size() != 0) begin
      sel = m_tags.pop_front();
      if (sel) begin m_bv = 1'b1; m_bd = rd; end
      else     begin m_av = 1'b1; m_ad = rd; end
      exp_q.push_back({sel, rd});
    end else if (rv) begin
      m_err = 1'b1;
    end
    if (iv && !full) m_tags.push_back(isel);
    @(posedge clk);
    #1;
    bus.issue_valid = 1'b0;
    bus.resp_valid  = 1'b0;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.issue_valid = 1'b0;
    bus.issue_sel   = 1'b0;
    bus.resp_valid  = 1'b0;
    bus.resp_data   = '0;
    model_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    check("reset_ready", 32'(bus.issue_ready), 32'(1));
    reset = 1'b0;

    // Ordering: A,B,B,A issued, then four responses.
    step(1, 0, 0, 0); step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 0, 0, 0);
    step(0, 0, 1, 32'h11);
    check("ord_a1", bus.out_a_data, 32'h11);
    step(0, 0, 1, 32'h22);
    check("ord_b1", bus.out_b_data, 32'h22);
    step(0, 0, 1, 32'h33);
    check("ord_b2", bus.out_b_data, 32'h33);
    step(0, 0, 1, 32'h44);
    check("ord_a2", bus.out_a_data, 32'h44);
    idle(1);

    // Full: four issues, fifth ignored, one response frees a slot.
    for (int i = 0; i < 4; i++) step(1, i[0], 0, 0);
    check("full_pending", 32'(bus.pending), 32'(4));
    check("full_ready",   32'(bus.issue_ready), 32'(0));
    step(1, 1, 0, 0);
    step(1, 1, 1, 32'h5555_0001);  // push blocked at full even with a pop
    check("full_after_pop", 32'(bus.pending), 32'(3));
    check("ready_after_pop", 32'(bus.issue_ready), 32'(1));
    for (int i = 0; i < 3; i++) step(0, 0, 1, 32'h5555_0010 + 32'(i));
    idle(1);

    // Simultaneous issue + response at pending=2 across pointer wraps.
    step(1, 0, 0, 0); step(1, 1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(1, 1'($urandom_range(0, 1)), 1, 32'h6000_0000 + 32'(i));
      check("sim_pending", 32'(bus.pending), 32'(2));
    end
    step(0, 0, 1, 32'h6000_00F0); step(0, 0, 1, 32'h6000_00F1);
    idle(1);

    // Underflow with an issue in the same cycle: no bypass.
    step(1, 0, 1, 32'hDEAD);
    check("uf_err",     32'(bus.err_underflow), 32'(1));
    check("uf_no_a",    32'(bus.out_a_valid), 32'(0));
    check("uf_pending", 32'(bus.pending), 32'(1));
    step(0, 0, 1, 32'h7777);
    check("uf_sticky",  32'(bus.err_underflow), 32'(1));

    // Hold: A pulse then B pulse; A data must persist.
    step(1, 0, 0, 0); step(1, 1, 0, 0);
    step(0, 0, 1, 32'hAAAA);
    step(0, 0, 1, 32'hBBBB);
    check("hold_a", bus.out_a_data, 32'hAAAA);
    check("hold_b", bus.out_b_data, 32'hBBBB);

    // Async reset mid-stream with three outstanding.
    step(1, 0, 0, 0); step(1, 1, 0, 0); step(1, 0, 0, 0);
    check("pre_rst_pending", 32'(bus.pending), 32'(3));
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs();
    check("rst_ready", 32'(bus.issue_ready), 32'(1));
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 99) < 45), $urandom);
    end
    while (m_tags.size() != 0) step(0, 0, 1, $urandom);
    idle(1);
    check("sb_drained", 32'(exp_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
